rlo_store_unit: RTL and testbench
=================================

# rlo_store_unit

Consumer side of the RLO path in each PLC core. On a one-cycle store command it captures the current RLO and applies the selected bit-write operation to one of four destinations:
- a data-RAM bit, using byte read-modify-write;
- a register bit;
- the semaphore;
- the local coil output byte.

It sequences the RAM handshake and reports completion to the instruction sequencer.

## Interface
- ADDR_W, 10, data RAM byte-address width
- DATA_W, 8, RAM data width and Q_Out width (bit select is 3 bits, so DATA_W = 8)
- TIMEOUT, 15, maximum cycles spent waiting for RAM_RdValid
- CLK  in  1  clock, all logic on rising edge
- CPU_Reset  in  1  synchronous, active-high reset
- ST_EN  in  1  start pulse; accepted only when idle
- ST_OPCode  in  3  000 assign, 001 set, 010 reset, 011 assign-inverted, 100 toggle-if-RLO, 101–111 no-op
- ST_Dest  in  2  0 RAM bit, 1 register bit, 2 semaphore, 3 coil byte Q_Out
- ST_Addr  in  ADDR_W  RAM byte address (destination 0 only)
- ST_BitSel  in  3  bit index within the byte, register index, or Q_Out bit
- RLO  in  1  current result of logic operation
- ST_Busy  out  1  command in progress
- ST_Done  out  1  one-cycle completion pulse
- ST_Err  out  1  one-cycle pulse with ST_Done on RAM timeout
- RAM_Addr  out  ADDR_W  RAM address
- RAM_RdEn  out  1  one-cycle read request
- RAM_RdData  in  DATA_W  read data
- RAM_RdValid  in  1  RAM_RdData valid
- RAM_WrEn  out  1  one-cycle write strobe
- RAM_WrData  out  DATA_W  modified byte
- REG_Sel  out  3  register bit index
- REG_RdBit  in  1  current value of the selected register bit; combinational from REG_Sel
- REG_WrEn  out  1  one-cycle register write strobe
- REG_WrBit  out  1  register write value
- SEM_Set  out  1  one-cycle semaphore set pulse
- SEM_Clr  out  1  one-cycle semaphore clear pulse
- Q_Out  out  DATA_W  coil output byte, held internally

## Operation
- Command capture: on ST_EN while IDLE, latch opcode, destination, address, bit select, and RLO into the captured value `r`. ST_EN while busy is ignored.
- Target value v and write-enable w, computed from the opcode and `r`:
  - assign: v = r, w = 1
  - assign-inverted: v = ~r, w = 1
  - set: v = 1, w = r
  - reset: v = 0, w = r
  - toggle: v = ~old, w = r
  - no-op: w = 0
- Short-circuit: if w = 0 the command completes without touching any destination, including RAM.
- States: IDLE, EXEC, RD_REQ, RD_WAIT, WR, DONE.
- IDLE → RD_REQ when destination is RAM and w = 1; otherwise IDLE → EXEC.
- EXEC (destinations 1–3, or w = 0):
  - Register destination: drive REG_Sel. For non-toggle ops, REG_WrEn with REG_WrBit = v, then DONE. For toggle, sample REG_RdBit in this cycle and write ~REG_RdBit in the next cycle, then DONE.
  - Semaphore destination: SEM_Set if v = 1, SEM_Clr if v = 0. Toggle on the semaphore is a no-op.
  - Coil destination: Q_Out[bit] <= v. Toggle uses the current Q_Out[bit].
- RD_REQ: RAM_RdEn = 1 and RAM_Addr = captured address for one cycle, then go to RD_WAIT.
- RD_WAIT: wait for RAM_RdValid. Capture RAM_RdData, replace bit [BitSel] with v (v = ~old bit for toggle), go to WR.
- RD_WAIT timeout: TIMEOUT cycles without RAM_RdValid → DONE with ST_Err, and no write is issued.
- WR: RAM_WrEn = 1, RAM_WrData = modified byte, RAM_Addr held, for one cycle, then DONE.
- DONE: ST_Done = 1 for one cycle, then IDLE.
- RAM_RdValid arriving outside RD_WAIT is ignored.
- All strobes (RdEn, WrEn, REG_WrEn, SEM_Set, SEM_Clr, Done, Err) are registered and last exactly one cycle.

## Timing
- Reset values: state IDLE, Q_Out = 0, RAM_Addr = 0, RAM_WrData = 0, REG_Sel = 0, REG_WrBit = 0, all strobes 0, ST_Busy = 0.
- ST_Busy is high from the cycle after acceptance through the ST_Done cycle inclusive. Earliest next acceptance is the cycle after ST_Done.
- Latency with acceptance at cycle 0:
  - Non-RAM, non-register-toggle: write strobe in cycle 1, ST_Done in cycle 2.
  - Register toggle: REG_WrEn in cycle 2, ST_Done in cycle 3.
  - RAM with a 1-cycle RAM: RdEn c1, RdValid c2, WrEn c3, Done c4.
- RLO changes after cycle 0 have no effect on the command in progress.
- CPU_Reset at any point, including between RdEn and WrEn, forces IDLE on the next edge. No further strobes are issued, a pending RAM write is dropped, and Q_Out clears.
- RAM_RdValid and ST_EN in the same cycle: the data completes the current command, and ST_EN is ignored.

## Test plan
- Dest 3, assign, RLO = 1, BitSel = 5, from reset → Q_Out = 0x20, ST_Done 2 cycles after ST_EN. Then reset op, RLO = 1 → Q_Out = 0x00.
- Dest 0, set, RLO = 1, Addr = 0x012, BitSel = 3, RAM returns 0xA1 → RdEn c1, WrEn c3 with RAM_Addr 0x012 and RAM_WrData 0xA9, Done c4.
- Dest 0, toggle, RLO = 0 → no RdEn and no WrEn, ST_Done at c2. Same command with RLO = 1 and RAM data 0xFF, BitSel = 0 → RAM_WrData 0xFE.
- Dest 0, assign, RAM never asserts RdValid → ST_Done and ST_Err together at cycle 1 + 1 + 15, and no WrEn.
- Dest 1, toggle, RLO = 1, BitSel = 2, REG_RdBit = 1 → REG_Sel = 2, REG_WrEn at c2 with REG_WrBit = 0. Dest 2, assign-inverted, RLO = 1 → single SEM_Clr pulse.
- CPU_Reset asserted in RD_WAIT → next cycle ST_Busy = 0, no WrEn ever issued. A second ST_EN pulsed while busy → no extra ST_Done.

Source files
------------

// File: rtl/rlo_store_unit.sv
// RLO store unit: captures RLO on a store command and applies a bit-write to a
// RAM bit (byte read-modify-write), a register bit, the semaphore or the coil byte.
module rlo_store_unit #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              CPU_Reset,
    input  logic              ST_EN,
    input  logic [2:0]        ST_OPCode,
    input  logic [1:0]        ST_Dest,
    input  logic [ADDR_W-1:0] ST_Addr,
    input  logic [2:0]        ST_BitSel,
    input  logic              RLO,
    output logic              ST_Busy,
    output logic              ST_Done,
    output logic              ST_Err,
    output logic [ADDR_W-1:0] RAM_Addr,
    output logic              RAM_RdEn,
    input  logic [DATA_W-1:0] RAM_RdData,
    input  logic              RAM_RdValid,
    output logic              RAM_WrEn,
    output logic [DATA_W-1:0] RAM_WrData,
    output logic [2:0]        REG_Sel,
    input  logic              REG_RdBit,
    output logic              REG_WrEn,
    output logic              REG_WrBit,
    output logic              SEM_Set,
    output logic              SEM_Clr,
    output logic [DATA_W-1:0] Q_Out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_ASG  = 3'b000;
    localparam logic [2:0] OP_SET  = 3'b001;
    localparam logic [2:0] OP_RST  = 3'b010;
    localparam logic [2:0] OP_ASGN = 3'b011;
    localparam logic [2:0] OP_TGL  = 3'b100;

    localparam logic [1:0] DEST_RAM  = 2'd0;
    localparam logic [1:0] DEST_REG  = 2'd1;
    localparam logic [1:0] DEST_SEM  = 2'd2;
    localparam logic [1:0] DEST_COIL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_RD_REQ, S_RD_WAIT, S_WR, S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_dest;
    logic [2:0]         r_bit;
    logic               r_v;
    logic               r_w;
    logic               r_tgl;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_rd_en;
    logic               r_wr_en;
    logic [DATA_W-1:0]  r_wr_data;
    logic [2:0]         r_reg_sel;
    logic               r_reg_wr_en;
    logic               r_reg_wr_bit;
    logic               r_sem_set;
    logic               r_sem_clr;
    logic [DATA_W-1:0]  r_q_out;

    logic               w_v;
    logic               w_w;
    logic               w_is_tgl;
    logic [DATA_W-1:0]  w_mod;

    // Target value and write-enable from the incoming opcode and live RLO.
    // Toggle's value is only meaningful here for the coil; RAM and register
    // toggles resolve the old bit later from the captured r_tgl flag.
    always_comb begin
        w_v      = 1'b0;
        w_w      = 1'b0;
        w_is_tgl = (ST_OPCode == OP_TGL);
        case (ST_OPCode)
            OP_ASG:  begin w_v = RLO;                  w_w = 1'b1; end
            OP_SET:  begin w_v = 1'b1;                 w_w = RLO;  end
            OP_RST:  begin w_v = 1'b0;                 w_w = RLO;  end
            OP_ASGN: begin w_v = ~RLO;                 w_w = 1'b1; end
            OP_TGL:  begin w_v = ~r_q_out[ST_BitSel];  w_w = RLO & (ST_Dest != DEST_SEM); end
            default: begin w_v = 1'b0;                 w_w = 1'b0; end
        endcase
    end

    // Read data with the selected bit replaced by the target value.
    always_comb begin
        w_mod        = RAM_RdData;
        w_mod[r_bit] = r_tgl ? ~RAM_RdData[r_bit] : r_v;
    end

    // Command sequencer with registered strobes and outputs.
    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dest       <= 2'd0;
            r_bit        <= 3'd0;
            r_v          <= 1'b0;
            r_w          <= 1'b0;
            r_tgl        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ram_addr   <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_reg_sel    <= 3'd0;
            r_reg_wr_en  <= 1'b0;
            r_reg_wr_bit <= 1'b0;
            r_sem_set    <= 1'b0;
            r_sem_clr    <= 1'b0;
            r_q_out      <= '0;
        end else begin
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_reg_wr_en <= 1'b0;
            r_sem_set   <= 1'b0;
            r_sem_clr   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ST_EN) begin
                        r_busy <= 1'b1;
                        r_dest <= ST_Dest;
                        r_bit  <= ST_BitSel;
                        r_v    <= w_v;
                        r_w    <= w_w;
                        r_tgl  <= w_is_tgl;
                        if (ST_Dest == DEST_REG) begin
                            r_reg_sel <= ST_BitSel;
                        end
                        if ((ST_Dest == DEST_RAM) && w_w) begin
                            r_state    <= S_RD_REQ;
                            r_rd_en    <= 1'b1;
                            r_ram_addr <= ST_Addr;
                        end else begin
                            r_state <= S_EXEC;
                            if (w_w) begin
                                case (ST_Dest)
                                    DEST_REG: begin
                                        if (!w_is_tgl) begin
                                            r_reg_wr_en  <= 1'b1;
                                            r_reg_wr_bit <= w_v;
                                        end
                                    end
                                    DEST_SEM: begin
                                        r_sem_set <= w_v;
                                        r_sem_clr <= ~w_v;
                                    end
                                    DEST_COIL: r_q_out[ST_BitSel] <= w_v;
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                S_EXEC: begin
                    // Register toggle: REG_RdBit is valid this cycle for the REG_Sel set at acceptance.
                    if (r_w && r_tgl && (r_dest == DEST_REG)) begin
                        r_reg_wr_en  <= 1'b1;
                        r_reg_wr_bit <= ~REG_RdBit;
                        r_state      <= S_WR;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (RAM_RdValid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_mod;
                        r_state   <= S_WR;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ST_Busy    = r_busy;
    assign ST_Done    = r_done;
    assign ST_Err     = r_err;
    assign RAM_Addr   = r_ram_addr;
    assign RAM_RdEn   = r_rd_en;
    assign RAM_WrEn   = r_wr_en;
    assign RAM_WrData = r_wr_data;
    assign REG_Sel    = r_reg_sel;
    assign REG_WrEn   = r_reg_wr_en;
    assign REG_WrBit  = r_reg_wr_bit;
    assign SEM_Set    = r_sem_set;
    assign SEM_Clr    = r_sem_clr;
    assign Q_Out      = r_q_out;

endmodule

// File: tb/tb_rlo_store_unit.sv
// Scoreboard bench for rlo_store_unit: stimulus pushes predicted strobe events
// with their cycle; a negedge monitor pops and compares every observed strobe.
module tb_rlo_store_unit;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    localparam int K_RD = 1, K_WR = 2, K_REG = 3, K_SET = 4, K_CLR = 5, K_DONE = 6;

    logic              CLK = 1'b0;
    logic              CPU_Reset;
    logic              ST_EN;
    logic [2:0]        ST_OPCode;
    logic [1:0]        ST_Dest;
    logic [ADDR_W-1:0] ST_Addr;
    logic [2:0]        ST_BitSel;
    logic              RLO;
    logic              ST_Busy, ST_Done, ST_Err;
    logic [ADDR_W-1:0] RAM_Addr;
    logic              RAM_RdEn;
    logic [DATA_W-1:0] RAM_RdData;
    logic              RAM_RdValid;
    logic              RAM_WrEn;
    logic [DATA_W-1:0] RAM_WrData;
    logic [2:0]        REG_Sel;
    logic              REG_RdBit;
    logic              REG_WrEn, REG_WrBit;
    logic              SEM_Set, SEM_Clr;
    logic [DATA_W-1:0] Q_Out;

    typedef struct { int cyc; int kind; int val; } ev_t;
    ev_t evq[$];

    logic [7:0] mem [1024];
    logic [7:0] reg_file;
    logic [7:0] exp_q;
    int cyc = 0;
    int ram_delay;
    int busy_lo, busy_hi;
    int n_cmp = 0, n_err = 0;
    bit mon_on = 1'b0;

    rlo_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .CPU_Reset(CPU_Reset), .ST_EN(ST_EN), .ST_OPCode(ST_OPCode),
        .ST_Dest(ST_Dest), .ST_Addr(ST_Addr), .ST_BitSel(ST_BitSel), .RLO(RLO),
        .ST_Busy(ST_Busy), .ST_Done(ST_Done), .ST_Err(ST_Err), .RAM_Addr(RAM_Addr),
        .RAM_RdEn(RAM_RdEn), .RAM_RdData(RAM_RdData), .RAM_RdValid(RAM_RdValid),
        .RAM_WrEn(RAM_WrEn), .RAM_WrData(RAM_WrData), .REG_Sel(REG_Sel),
        .REG_RdBit(REG_RdBit), .REG_WrEn(REG_WrEn), .REG_WrBit(REG_WrBit),
        .SEM_Set(SEM_Set), .SEM_Clr(SEM_Clr), .Q_Out(Q_Out)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign REG_RdBit = reg_file[REG_Sel];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input int v);
        evq.push_back('{c, k, v});
    endtask

    task automatic got_ev(input int k, input int v);
        ev_t e;
        n_cmp++;
        if (evq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: got kind=%0d val=%0h cyc=%0d, want none", k, v, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                n_err++;
                $display("FAIL strobe: got kind=%0d val=%0h cyc=%0d, want kind=%0d val=%0h cyc=%0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every observed strobe must match the head of the expected queue.
    always @(negedge CLK) begin
        if (mon_on) begin
            chk("busy", {31'd0, ST_Busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
            chk("q_out", {24'd0, Q_Out}, {24'd0, exp_q});
            if (RAM_RdEn)  got_ev(K_RD, int'(RAM_Addr));
            if (RAM_WrEn)  got_ev(K_WR, (int'(RAM_Addr) << 8) | int'(RAM_WrData));
            if (REG_WrEn)  got_ev(K_REG, (int'(REG_Sel) << 1) | int'(REG_WrBit));
            if (SEM_Set)   got_ev(K_SET, 0);
            if (SEM_Clr)   got_ev(K_CLR, 0);
            if (ST_Done || ST_Err) got_ev(K_DONE, (int'(ST_Done) << 1) | int'(ST_Err));
        end
    end

    // RAM responder: RdValid d cycles after a read request; d = 0 never answers.
    initial begin
        RAM_RdValid = 1'b0;
        RAM_RdData  = '0;
        forever begin
            @(posedge CLK); #1;
            if (RAM_RdEn === 1'b1 && ram_delay > 0) begin
                int d;
                logic [ADDR_W-1:0] a;
                d = ram_delay;
                a = RAM_Addr;
                repeat (d) @(posedge CLK);
                #1;
                RAM_RdValid = 1'b1;
                RAM_RdData  = mem[a];
                @(posedge CLK); #1;
                RAM_RdValid = 1'b0;
                RAM_RdData  = $urandom;
            end
        end
    end

    // Issue one command (called 1 time unit after a rising edge) and predict its effects.
    task automatic issue(input int op, input int dest, input int addr, input int bsel,
                         input int rlo, input int d, input int data, input int regs, input bit stray);
        int a, done_c, err;
        bit v, w, tgl;
        logic [7:0] b, nq;
        a = cyc;
        ST_EN = 1'b1; ST_OPCode = op[2:0]; ST_Dest = dest[1:0];
        ST_Addr = addr[ADDR_W-1:0]; ST_BitSel = bsel[2:0]; RLO = rlo[0];
        ram_delay = d;
        mem[addr[ADDR_W-1:0]] = data[7:0];
        reg_file = regs[7:0];
        tgl = (op == 4);
        v = 1'b0; w = 1'b0; err = 0;
        case (op)
            0: begin v = rlo[0];  w = 1'b1;   end
            1: begin v = 1'b1;    w = rlo[0]; end
            2: begin v = 1'b0;    w = rlo[0]; end
            3: begin v = !rlo[0]; w = 1'b1;   end
            4: begin v = 1'b0;    w = rlo[0]; end
            default: w = 1'b0;
        endcase
        if (tgl && dest == 2) w = 1'b0;
        nq = exp_q;
        if (!w) begin
            done_c = a + 2;
        end else if (dest == 0) begin
            push(a + 1, K_RD, addr);
            if (d >= 1 && d <= TIMEOUT) begin
                b = data[7:0];
                b[bsel] = tgl ? !data[bsel] : v;
                push(a + 2 + d, K_WR, (addr << 8) | int'(b));
                done_c = a + 3 + d;
            end else begin
                done_c = a + 2 + TIMEOUT;
                err = 1;
            end
        end else if (dest == 1) begin
            if (tgl) begin
                push(a + 2, K_REG, (bsel << 1) | int'(!regs[bsel]));
                done_c = a + 3;
            end else begin
                push(a + 1, K_REG, (bsel << 1) | int'(v));
                done_c = a + 2;
            end
        end else if (dest == 2) begin
            push(a + 1, v ? K_SET : K_CLR, 0);
            done_c = a + 2;
        end else begin
            nq[bsel] = tgl ? !exp_q[bsel] : v;
            done_c = a + 2;
        end
        push(done_c, K_DONE, 2 | err);
        busy_lo = a + 1;
        busy_hi = done_c;
        @(posedge CLK); #1;
        ST_EN = 1'b0;
        RLO = $urandom;
        exp_q = nq;
        while (cyc <= done_c) begin
            if (stray && $urandom_range(0, 2) == 0) begin
                ST_EN = 1'b1; ST_OPCode = $urandom; ST_Dest = $urandom;
                ST_Addr = $urandom; ST_BitSel = $urandom;
            end else begin
                ST_EN = 1'b0;
            end
            @(posedge CLK); #1;
        end
        ST_EN = 1'b0;
    endtask

    initial begin
        int a;
        CPU_Reset = 1'b1; ST_EN = 1'b0; ST_OPCode = 3'd0; ST_Dest = 2'd0;
        ST_Addr = '0; ST_BitSel = 3'd0; RLO = 1'b0; ram_delay = 0;
        reg_file = 8'h00; exp_q = 8'h00; busy_lo = 1; busy_hi = 0;
        repeat (3) @(posedge CLK);
        #1;
        CPU_Reset = 1'b0;
        chk("rst_busy", {31'd0, ST_Busy}, 32'd0);
        chk("rst_q", {24'd0, Q_Out}, 32'd0);
        chk("rst_ram_addr", {22'd0, RAM_Addr}, 32'd0);
        chk("rst_wr_data", {24'd0, RAM_WrData}, 32'd0);
        chk("rst_reg_sel", {29'd0, REG_Sel}, 32'd0);
        chk("rst_reg_wr_bit", {31'd0, REG_WrBit}, 32'd0);
        mon_on = 1'b1;

        // Coil assign then reset
        issue(0, 3, 0, 5, 1, 0, 0, 0, 1'b0);
        chk("coil_assign", {24'd0, Q_Out}, 32'h20);
        issue(2, 3, 0, 5, 1, 0, 0, 0, 1'b0);
        chk("coil_reset", {24'd0, Q_Out}, 32'h00);
        // RAM set with 1-cycle RAM, toggle short-circuit, toggle with data
        issue(1, 0, 12'h012, 3, 1, 1, 8'hA1, 0, 1'b0);
        issue(4, 0, 12'h012, 0, 0, 1, 8'hFF, 0, 1'b0);
        issue(4, 0, 12'h012, 0, 1, 1, 8'hFF, 0, 1'b0);
        // RAM timeout, and boundary delays
        issue(0, 0, 12'h155, 4, 1, 0, 8'h3C, 0, 1'b0);
        issue(0, 0, 12'h156, 6, 0, TIMEOUT, 8'hC3, 0, 1'b0);
        issue(3, 0, 12'h157, 7, 0, TIMEOUT + 1, 8'h00, 0, 1'b0);
        // Register toggle and semaphore clear
        issue(4, 1, 0, 2, 1, 0, 0, 8'h04, 1'b0);
        chk("reg_sel", {29'd0, REG_Sel}, 32'd2);
        issue(3, 2, 0, 0, 1, 0, 0, 0, 1'b0);

        // Reset while waiting for RAM data: only the read request may appear
        a = cyc;
        ST_EN = 1'b1; ST_OPCode = 3'd0; ST_Dest = 2'd0; ST_Addr = 10'h2AA;
        ST_BitSel = 3'd1; RLO = 1'b1; ram_delay = 0;
        push(a + 1, K_RD, 'h2AA);
        busy_lo = a + 1; busy_hi = a + 1000;
        @(posedge CLK); #1; ST_EN = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        CPU_Reset = 1'b1; busy_hi = cyc;
        @(posedge CLK); #1;
        CPU_Reset = 1'b0; exp_q = 8'h00;
        repeat (20) @(posedge CLK);
        #1;

        // Randomized commands with stray ST_EN pulses while busy
        for (int i = 0; i < 150; i++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1023),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, TIMEOUT + 1),
                  $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("events_drained", evq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
